// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the register-file command controller.
// Build option CMD_ERR_RESP_EN (see sys_ctrl_rf) uses ERR_BYTE.
package sys_ctrl_pkg;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 4;
   localparam int RD_TIMEOUT = 15;

   localparam logic [7:0] CMD_WR   = 8'hAA;
   localparam logic [7:0] CMD_RD   = 8'hBB;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } state_e;

endpackage

// File: rtl/sys_ctrl_tx_hold.sv
// Holds the byte bound for the UART transmitter and issues its one-cycle request.
// tx_vld_o is a request the transmitter accepts in that same cycle; it is only raised while tx_busy_i is low.
module sys_ctrl_tx_hold #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cap_i,
   input  logic [DATA_W-1:0] cap_data_i,
   input  logic              tx_busy_i,
   output logic [DATA_W-1:0] tx_data_o,
   output logic              tx_vld_o
);

   logic [DATA_W-1:0] data_q;
   logic              pend_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         pend_q <= 1'b0;
      end else if (cap_i) begin
         data_q <= cap_data_i;
         pend_q <= 1'b1;
      end else if (tx_vld_o) begin
         pend_q <= 1'b0;
      end
   end

   // Gated combinationally so the request lands on the very first idle cycle.
   assign tx_vld_o  = pend_q & ~tx_busy_i;
   assign tx_data_o = data_q;

endmodule

// File: rtl/sys_ctrl_rf.sv
// Command decoder between UART RX/TX and the 16x8 register file.
// Define CMD_ERR_RESP_EN to answer unknown opcodes and read timeouts with ERR_BYTE.
module sys_ctrl_rf #(
   parameter int                DATA_W     = sys_ctrl_pkg::DATA_W,
   parameter int                ADDR_W     = sys_ctrl_pkg::ADDR_W,
   parameter logic [DATA_W-1:0] CMD_WR     = sys_ctrl_pkg::CMD_WR,
   parameter logic [DATA_W-1:0] CMD_RD     = sys_ctrl_pkg::CMD_RD,
   parameter int                RD_TIMEOUT = sys_ctrl_pkg::RD_TIMEOUT
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [DATA_W-1:0] RX_P_DATA,
   input  logic              RX_D_VLD,
   output logic              WrEn,
   output logic              RdEn,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] WrData,
   input  logic [DATA_W-1:0] RdData,
   input  logic              RdData_Valid,
   output logic [DATA_W-1:0] TX_P_DATA,
   output logic              TX_D_VLD,
   input  logic              TX_Busy
);

   import sys_ctrl_pkg::*;

   localparam int               CNT_W    = $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              wr_en_q;
   logic              rd_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              cap;
   logic [DATA_W-1:0] cap_data;
   logic              tx_fire;
   logic              rd_expire;

   // The wait counter shows RD_TIMEOUT-1 in the last cycle a read response is still accepted.
   assign rd_expire = (state_q == RD_WAIT) && !RdData_Valid && (cnt_q == CNT_LAST);

   always_comb begin
      cap      = 1'b0;
      cap_data = RdData;
      if (state_q == RD_WAIT && RdData_Valid) begin
         cap = 1'b1;
      end
`ifdef CMD_ERR_RESP_EN
      if (rd_expire) begin
         cap      = 1'b1;
         cap_data = DATA_W'(ERR_BYTE);
      end
      if (state_q == IDLE && RX_D_VLD && RX_P_DATA != CMD_WR && RX_P_DATA != CMD_RD) begin
         cap      = 1'b1;
         cap_data = DATA_W'(ERR_BYTE);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == CMD_WR)      state_q <= WR_ADDR;
                  else if (RX_P_DATA == CMD_RD) state_q <= RD_ADDR;
                  else if (cap)                 state_q <= TX_SEND;
               end
            end
            WR_ADDR: begin
               if (RX_D_VLD) begin
                  addr_q  <= RX_P_DATA[ADDR_W-1:0];
                  state_q <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (RX_D_VLD) begin
                  wr_data_q <= RX_P_DATA;
                  wr_en_q   <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            RD_ADDR: begin
               if (RX_D_VLD) begin
                  addr_q  <= RX_P_DATA[ADDR_W-1:0];
                  rd_en_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (RdData_Valid)   state_q <= TX_SEND;
               else if (rd_expire) state_q <= cap ? TX_SEND : IDLE;
               else                cnt_q   <= cnt_q + 1'b1;
            end
            TX_SEND: begin
               if (tx_fire) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sys_ctrl_tx_hold #(
      .DATA_W (DATA_W)
   ) u_tx_hold (
      .clk_i      (clk),
      .rst_i      (RST),
      .cap_i      (cap),
      .cap_data_i (cap_data),
      .tx_busy_i  (TX_Busy),
      .tx_data_o  (TX_P_DATA),
      .tx_vld_o   (tx_fire)
   );

   assign TX_D_VLD = tx_fire;
   assign WrEn     = wr_en_q;
   assign RdEn     = rd_en_q;
   assign Address  = addr_q;
   assign WrData   = wr_data_q;

endmodule

// File: tb/tb_sys_ctrl_rf.sv
// Directed bench for sys_ctrl_rf: frame decoding, read/transmit handshake, timeout, reset abort.
// Expectations follow CMD_ERR_RESP_EN when the bench is built with it.
module tb_sys_ctrl_rf;

   logic       clk = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic       WrEn;
   logic       RdEn;
   logic [3:0] Address;
   logic [7:0] WrData;
   logic [7:0] RdData;
   logic       RdData_Valid;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_Busy;

   int vectors     = 0;
   int miscompares = 0;
   int tx_cnt      = 0;
   int wr_cnt      = 0;
   logic [7:0] exp_q[$];

   sys_ctrl_rf dut (
      .clk          (clk),
      .RST          (RST),
      .RX_P_DATA    (RX_P_DATA),
      .RX_D_VLD     (RX_D_VLD),
      .WrEn         (WrEn),
      .RdEn         (RdEn),
      .Address      (Address),
      .WrData       (WrData),
      .RdData       (RdData),
      .RdData_Valid (RdData_Valid),
      .TX_P_DATA    (TX_P_DATA),
      .TX_D_VLD     (TX_D_VLD),
      .TX_Busy      (TX_Busy)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // drivers: inputs change and checks happen 1 time unit after the falling edge
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
   endtask

   task automatic rd_resp(input logic [7:0] d);
      RdData       = d;
      RdData_Valid = 1'b1;
      tick();
      RdData_Valid = 1'b0;
   endtask

   // scoreboard: every transmit request must match the head of exp_q
   always @(negedge clk) begin
      #3;
      if (!RST) begin
         if (WrEn) wr_cnt++;
         if (WrEn && RdEn) chk("wr_rd_excl", 1, 0);
         if (TX_D_VLD) begin
            tx_cnt++;
            chk("tx_while_busy", TX_Busy, 0);
            if (exp_q.size() == 0) chk("tx_unexpected", TX_P_DATA, 0);
            else                   chk("tx_data", TX_P_DATA, exp_q.pop_front());
         end
      end
   end

   initial begin
      int exp_tx;
      RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0;
      RdData = '0; RdData_Valid = 1'b0; TX_Busy = 1'b0;
      exp_tx = 3;

      // reset state
      idle(3);
      chk("rst_wren", WrEn, 0);
      chk("rst_rden", RdEn, 0);
      chk("rst_txvld", TX_D_VLD, 0);
      chk("rst_addr", Address, 0);
      chk("rst_wrdata", WrData, 0);
      chk("rst_txdata", TX_P_DATA, 0);
      RST = 1'b0;

      // write AA 05 3C, then read address 5 back
      send_byte(8'hAA); idle(1);
      send_byte(8'h05); idle(1);
      chk("wr_early", WrEn, 0);
      send_byte(8'h3C);
      chk("wr_en", WrEn, 1);
      chk("wr_addr", Address, 5);
      chk("wr_data", WrData, 8'h3C);
      chk("wr_no_rden", RdEn, 0);
      tick();
      chk("wr_en_drop", WrEn, 0);

      send_byte(8'hBB);
      send_byte(8'h05);
      chk("rd_en", RdEn, 1);
      chk("rd_addr", Address, 5);
      chk("rd_no_wren", WrEn, 0);
      tick();
      chk("rd_en_drop", RdEn, 0);
      exp_q.push_back(8'h3C);
      rd_resp(8'h3C);
      chk("rb_txvld", TX_D_VLD, 1);
      chk("rb_txdata", TX_P_DATA, 8'h3C);
      tick();
      chk("rb_txvld_drop", TX_D_VLD, 0);

      // read with busy transmitter; stray bytes in RD_WAIT and TX_SEND are dropped
      TX_Busy = 1'b1;
      send_byte(8'hBB);
      send_byte(8'h03);
      chk("rdb_en", RdEn, 1);
      chk("rdb_addr", Address, 3);
      send_byte(8'hAA);
      idle(1);
      exp_q.push_back(8'h77);
      rd_resp(8'h77);
      for (int i = 0; i < 9; i++) begin
         chk("rdb_hold", TX_D_VLD, 0);
         if (i == 4) send_byte(8'hBB);
         else        tick();
      end
      TX_Busy = 1'b0;
      #1;
      chk("rdb_txvld", TX_D_VLD, 1);
      chk("rdb_txdata", TX_P_DATA, 8'h77);
      tick();
      chk("rdb_txvld_drop", TX_D_VLD, 0);
      chk("rdb_txdata_hold", TX_P_DATA, 8'h77);

      send_byte(8'hAA); send_byte(8'h0A); send_byte(8'hE1);
      chk("after_drop_wren", WrEn, 1);
      chk("after_drop_addr", Address, 4'hA);
      chk("after_drop_data", WrData, 8'hE1);
      tick();

      // timeout: RdEn cycle counts as wait cycle 1, the 15th is the last one accepted
      send_byte(8'hBB);
      send_byte(8'h02);
      idle(14);
      chk("to_pending", TX_D_VLD, 0);
`ifdef CMD_ERR_RESP_EN
      exp_q.push_back(8'hEE);
      exp_tx++;
      tick();
      chk("to_err_vld", TX_D_VLD, 1);
      chk("to_err_data", TX_P_DATA, 8'hEE);
`else
      tick();
      chk("to_no_tx", TX_D_VLD, 0);
      chk("to_data_hold", TX_P_DATA, 8'h77);
`endif
      rd_resp(8'h99);
      idle(3);

      // response in the 15th wait cycle still wins
      send_byte(8'hBB);
      send_byte(8'h06);
      idle(14);
      exp_q.push_back(8'h5A);
      rd_resp(8'h5A);
      chk("edge_txvld", TX_D_VLD, 1);
      chk("edge_txdata", TX_P_DATA, 8'h5A);
      tick();

      // unknown opcode, then a normal write
`ifdef CMD_ERR_RESP_EN
      exp_q.push_back(8'hEE);
      exp_tx++;
`endif
      send_byte(8'h12);
      chk("unk_wren", WrEn, 0);
      chk("unk_rden", RdEn, 0);
`ifdef CMD_ERR_RESP_EN
      chk("unk_err_vld", TX_D_VLD, 1);
      chk("unk_err_data", TX_P_DATA, 8'hEE);
`else
      chk("unk_no_tx", TX_D_VLD, 0);
`endif
      tick();
      send_byte(8'hAA); idle(1);
      send_byte(8'h01); idle(1);
      send_byte(8'h55);
      chk("unk_next_wren", WrEn, 1);
      chk("unk_next_addr", Address, 1);
      chk("unk_next_data", WrData, 8'h55);
      tick();

      // reset in the middle of a write frame
      send_byte(8'hAA);
      send_byte(8'h04);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("mr_wren", WrEn, 0);
      chk("mr_rden", RdEn, 0);
      chk("mr_txvld", TX_D_VLD, 0);
      chk("mr_addr", Address, 0);
      chk("mr_wrdata", WrData, 0);
      chk("mr_txdata", TX_P_DATA, 0);
`ifdef CMD_ERR_RESP_EN
      exp_q.push_back(8'hEE);
      exp_tx++;
`endif
      send_byte(8'h99);
      chk("mr_no_write", WrEn, 0);
      tick();

      // reset discards a captured byte still waiting on a busy transmitter
      TX_Busy = 1'b1;
      send_byte(8'hBB);
      send_byte(8'h07);
      idle(1);
      rd_resp(8'hC3);
      chk("abort_captured", TX_P_DATA, 8'hC3);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      TX_Busy = 1'b0;
      idle(4);
      chk("abort_txdata", TX_P_DATA, 0);

      // final report
      chk("tx_total", tx_cnt, exp_tx);
      chk("tx_leftover", exp_q.size(), 0);
      chk("wr_total", wr_cnt, 3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
